// File: rtl/filtro_pasa_baja_200_hz_pkg.sv
// Shared constants, coefficients, FSM state type and saturation helper for the 200 Hz low-pass filter.
// Latency: none (pure definitions).
// Backpressure: none.
package filtro_pkg;

    localparam int N     = 25;
    localparam int FRAC  = 15;
    localparam int ACC_W = 2 * N + 3;

    // Q9.15 coefficients, fc = 200 Hz at fs = 10 kHz
    localparam logic signed [N-1:0] B0 = 25'sd119;
    localparam logic signed [N-1:0] B1 = 25'sd237;
    localparam logic signed [N-1:0] B2 = 25'sd119;
    localparam logic signed [N-1:0] A1 = -25'sd59727;
    localparam logic signed [N-1:0] A2 = 25'sd27433;

    localparam logic signed [N-1:0] Y_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] Y_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Arithmetic shift right by FRAC (floor), then clamp to the N-bit range
    function automatic logic signed [N-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W-1:0] max_w;
        logic signed [ACC_W-1:0] min_w;
        sh    = v >>> FRAC;
        max_w = {{(ACC_W-N){1'b0}}, Y_MAX};
        min_w = {{(ACC_W-N){1'b1}}, Y_MIN};
        if (sh > max_w)
            return Y_MAX;
        else if (sh < min_w)
            return Y_MIN;
        else
            return sh[N-1:0];
    endfunction

endpackage

// File: rtl/filtro_pasa_baja_200_hz_if.sv
// Sample-in / filtered-sample-out bus between the ADC register and the filter.
// Latency: none (wiring only).
// Backpressure: none; the filter drops strobes that arrive while it is busy.
interface filtro_pasa_baja_200_hz_if;
    import filtro_pkg::*;

    logic signed [N-1:0] Uk;
    logic                Bandera_ADC;
    logic signed [N-1:0] Yk;
    logic                Bandera_Listo;

    modport master (output Uk, output Bandera_ADC, input Yk, input Bandera_Listo);
    modport slave  (input Uk, input Bandera_ADC, output Yk, output Bandera_Listo);

endinterface

// File: rtl/filtro_pasa_baja_200_hz_mac_sat.sv
// Signed sequential multiply-accumulate with arithmetic shift and N-bit saturation of the sum.
// Latency: one product folded into the accumulator per enabled cycle; saturated view is combinational.
// Backpressure: none; the controller sequences clr/en.
module filtro_mac_sat
    import filtro_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                sub_i,
    input  logic signed [N-1:0] coef_i,
    input  logic signed [N-1:0] data_i,
    output logic signed [N-1:0] y_sat_o
);

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Full-precision product, sign-extended to accumulator width
    always_comb begin
        prod     = coef_i * data_i;
        prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        acc_d    = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end

    // Accumulator register
    always_ff @(posedge Clk) begin
        if (Reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign y_sat_o = saturate(acc_q);

endmodule

// File: rtl/filtro_pasa_baja_200_hz.sv
// Second-order Butterworth IIR low-pass (DF-I) with a single shared multiplier.
// Latency: start edge = edge 0, Yk updates at edge 6, Bandera_Listo high between edges 7 and 8.
// Backpressure: none; rising strobes seen outside IDLE are dropped, a held-high strobe never retriggers.
module filtro_pasa_baja_200_hz
    import filtro_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Reset,
    filtro_pasa_baja_200_hz_if.slave bus
);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                adc_prev_q;
    logic signed [N-1:0] u0_q, u1_q, u2_q;
    logic signed [N-1:0] y1_q, y2_q;
    logic signed [N-1:0] yk_q;
    logic                listo_q;

    logic                start;
    logic                mac_clr, mac_en, mac_sub;
    logic signed [N-1:0] op_coef, op_data;
    logic signed [N-1:0] y_sat;

    assign start = (state_q == IDLE) && bus.Bandera_ADC && !adc_prev_q;

    // Next-state and MAC sequencing: five products, then saturate, then flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    cnt_d   = 3'd0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd4)
                    state_d = SAT;
            end
            SAT:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand mux: b0u0, b1u1, b2u2, then the two subtracted feedback terms
    always_comb begin
        op_coef = '0;
        op_data = '0;
        mac_sub = 1'b0;
        case (cnt_q)
            3'd0: begin op_coef = B0; op_data = u0_q; end
            3'd1: begin op_coef = B1; op_data = u1_q; end
            3'd2: begin op_coef = B2; op_data = u2_q; end
            3'd3: begin op_coef = A1; op_data = y1_q; mac_sub = 1'b1; end
            3'd4: begin op_coef = A2; op_data = y2_q; mac_sub = 1'b1; end
            default: begin op_coef = '0; op_data = '0; end
        endcase
    end

    filtro_mac_sat u_mac (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .sub_i   (mac_sub),
        .coef_i  (op_coef),
        .data_i  (op_data),
        .y_sat_o (y_sat)
    );

    // State, edge detect, sample capture and history shift on the SAT edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            adc_prev_q <= 1'b0;
            u0_q       <= '0;
            u1_q       <= '0;
            u2_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            yk_q       <= '0;
            listo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adc_prev_q <= bus.Bandera_ADC;
            listo_q    <= (state_q == DONE);
            if (start)
                u0_q <= bus.Uk;
            if (state_q == SAT) begin
                yk_q <= y_sat;
                u2_q <= u1_q;
                u1_q <= u0_q;
                y2_q <= y1_q;
                y1_q <= y_sat;
            end
        end
    end

    assign bus.Yk            = yk_q;
    assign bus.Bandera_Listo = listo_q;

endmodule

// File: tb/tb_filtro_pasa_baja_200_hz.sv
module tb_filtro_pasa_baja_200_hz;
    import filtro_pkg::*;

    typedef struct {
        int y;
        int cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    // reference model history
    longint m_u1 = 0, m_u2 = 0, m_y1 = 0, m_y2 = 0;

    filtro_pasa_baja_200_hz_if bus();

    filtro_pasa_baja_200_hz dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Difference equation with floor division by 2^15 and clamp to 25 bits
    function automatic int model_step(input int u);
        longint acc, y;
        acc = 119 * longint'(u) + 237 * m_u1 + 119 * m_u2
              + 59727 * m_y1 - 27433 * m_y2;
        y = acc >>> 15;
        if (y > 16777215)  y = 16777215;
        if (y < -16777216) y = -16777216;
        m_u2 = m_u1; m_u1 = u;
        m_y2 = m_y1; m_y1 = y;
        return int'(y);
    endfunction

    function automatic void model_clear();
        m_u1 = 0; m_u2 = 0; m_y1 = 0; m_y2 = 0;
    endfunction

    // One sample: strobe held 'hold' cycles, next strobe no earlier than gap+1 cycles later
    task automatic strobe(input int u, input int hold, input int gap);
        exp_t e;
        @(posedge Clk); #1;
        bus.Uk          = 25'(u);
        bus.Bandera_ADC = 1'b1;
        e.y   = model_step(u);
        e.cyc = cyc + 8;
        sb.push_back(e);
        for (int i = 0; i < gap; i++) begin
            @(posedge Clk); #1;
            if (i == 0) bus.Uk = 25'($urandom);
            if (i + 1 >= hold) bus.Bandera_ADC = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge Clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every Listo pulse pops one expectation
    initial forever begin
        exp_t e;
        @(posedge Clk); #1;
        if (bus.Bandera_Listo === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_listo: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("yk", int'(bus.Yk), e.y);
                check("listo_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset           = 1'b1;
        bus.Uk          = '0;
        bus.Bandera_ADC = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_yk", int'(bus.Yk), 0);
        check("reset_listo", int'(bus.Bandera_Listo), 0);

        // impulse
        strobe(32768, 1, 11);
        drain();
        check("first_sample_yk", int'(bus.Yk), 119);
        for (int i = 0; i < 30; i++) strobe(0, 1, 11);
        drain();

        // held-high strobe: single computation
        strobe(1000, 5, 11);
        drain();

        // second edge during computation is dropped
        strobe(5000, 1, 2);
        bus.Uk = 25'(-77777); bus.Bandera_ADC = 1'b1;
        @(posedge Clk); #1 bus.Bandera_ADC = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        drain();

        // reset during MAC aborts with no pulse and clears history
        @(posedge Clk); #1;
        bus.Uk = 25'(123456); bus.Bandera_ADC = 1'b1;
        @(posedge Clk); #1 bus.Bandera_ADC = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_clear();
        check("abort_yk", int'(bus.Yk), 0);
        check("abort_listo", int'(bus.Bandera_Listo), 0);
        repeat (12) @(posedge Clk);
        #1;
        strobe(32768, 1, 11);
        drain();

        // DC step
        for (int i = 0; i < 1000; i++) strobe(32768, 1, 11);
        drain();

        // ramp
        for (int i = 0; i < 1000; i++) strobe(i * 32, 1, 11);
        drain();

        // saturation at maximum strobe rate
        for (int i = 0; i < 40; i++) strobe((i % 2 == 0) ? 16777215 : -16777216, 1, 7);
        drain();
        for (int i = 0; i < 40; i++) strobe((i < 20) ? 16777215 : -16777216, 1, 7);
        drain();

        // random samples, holds and spacing
        for (int i = 0; i < 200; i++) begin
            int u, h, g;
            u = int'($urandom_range(33554431, 0)) - 16777216;
            h = int'($urandom_range(5, 1));
            g = int'($urandom_range(15, 7));
            strobe(u, h, g);
        end
        drain();

        repeat (4) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
